// File: rtl/bit_serializer_if.sv
// Parallel-in handshake and serial-out bundle between a word producer,
// the bit_serializer, and the downstream sequence detector.
`timescale 1ns/1ps
interface bit_serializer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]         din;
  logic                     din_valid;
  logic                     din_ready;
  logic                     a;
  logic                     a_valid;
  logic                     busy;
  logic [$clog2(DEPTH):0]   count;

  // Word producer / observer side.
  modport master (
    output din, din_valid,
    input  din_ready, a, a_valid, busy, count
  );

  // Serializer side.
  modport slave (
    input  din, din_valid,
    output din_ready, a, a_valid, busy, count
  );
endinterface

// File: rtl/bit_serializer.sv
// FIFO-buffered parallel-to-serial converter feeding the sequence detector:
// one bit per clock on a/a_valid, words emitted back to back without gaps.
`timescale 1ns/1ps
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  bit_serializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return w[WIDTH-1];
    else           return w[0];
  endfunction

  // Moves the next bit to emit into the lead position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
    else           return {1'b0, w[WIDTH-1:1]};
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             a_q, a_d;
  logic             a_valid_q, a_valid_d;
  logic             ready;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  assign ready         = rst && (count_q != CW'(DEPTH));
  assign push          = bus.din_valid && ready;
  assign head          = mem_q[rd_ptr_q];

  assign bus.din_ready = ready;
  assign bus.a         = a_q;
  assign bus.a_valid   = a_valid_q;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.count     = count_q;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bitcnt_d  = bitcnt_q;
    a_d       = a_q;
    a_valid_d = a_valid_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pop       = 1'b0;

    // Popping looks only at registered occupancy, so a word pushed this
    // edge is never popped on the same edge.
    case (state_q)
      IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      SHIFT: begin
        if (bitcnt_q != '0) begin
          a_d      = lead_bit(sreg_q);
          sreg_d   = advance(sreg_q);
          bitcnt_d = bitcnt_q - 1'b1;
        end else if (count_q != '0) begin
          pop = 1'b1;
        end else begin
          a_d       = 1'b0;
          a_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      a_d       = lead_bit(head);
      sreg_d    = advance(head);
      a_valid_d = 1'b1;
      bitcnt_d  = BW'(WIDTH - 1);
      state_d   = SHIFT;
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      a_q       <= 1'b0;
      a_valid_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.din;
    sreg_q <= sreg_d;
  end
endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: a word-schedule model predicts every output on
// every cycle, and directed scenarios pin the model with literal expectations.
`timescale 1ns/1ps
module tb_bit_serializer;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int NE = 2048;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(W), .DEPTH(D)) ifc ();
  bit_serializer_if #(.WIDTH(W), .DEPTH(D)) ifl ();

  bit_serializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bus(ifc.slave)
  );
  bit_serializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bus(ifl.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each accepted word is scheduled onto the output timeline at
  // max(push edge + 1, end of previous word); it leaves the FIFO at its start edge.
  int  cyc = 0;
  bit  exp_v [NE];
  bit  exp_b [NE];
  int  starts[$];
  int  next_free = 0;
  int  mcount = 0;
  bit  m_pop, m_push;
  int  m_s;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      foreach (exp_v[i]) begin
        exp_v[i] = 1'b0;
        exp_b[i] = 1'b0;
      end
      starts.delete();
      next_free = 0;
      mcount = 0;
    end else begin
      m_pop = (starts.size() > 0) && (starts[0] == cyc);
      if (m_pop) void'(starts.pop_front());
      m_push = (ifc.din_valid === 1'b1) && (mcount < D);
      if (m_push) begin
        m_s = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        for (int i = 0; i < W; i++) begin
          if (m_s + i < NE) begin
            exp_v[m_s + i] = 1'b1;
            exp_b[m_s + i] = ifc.din[W-1-i];
          end
        end
        starts.push_back(m_s);
        next_free = m_s + W;
      end
      mcount = mcount + int'(m_push) - int'(m_pop);
    end
  end

  bit cmp_en = 1'b0;
  always @(posedge clk) begin
    #2;
    if (cmp_en && cyc < NE) begin
      chk("cyc_a_valid",   ifc.a_valid,   exp_v[cyc]);
      chk("cyc_a",         ifc.a,         exp_v[cyc] & exp_b[cyc]);
      chk("cyc_busy",      ifc.busy,      exp_v[cyc]);
      chk("cyc_count",     ifc.count,     mcount);
      chk("cyc_din_ready", ifc.din_ready, (rst && mcount != D));
    end
  end

  bit cap_en = 1'b0;
  bit cap[$];
  always @(posedge clk) begin
    #2;
    if (cap_en && ifc.a_valid === 1'b1) cap.push_back(ifc.a);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  logic [7:0]  v8;
  logic [15:0] v16;
  logic [47:0] v48;
  logic [7:0]  words [6];
  int k, rel, last_edge;
  logic rdy;

  initial begin
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rst = 1'b0;
    ifc.din = '0; ifc.din_valid = 1'b1;
    ifl.din = '0; ifl.din_valid = 1'b0;

    // Reset held with din_valid high.
    repeat (5) @(posedge clk);
    #2;
    chk("rst_a",         ifc.a,         0);
    chk("rst_a_valid",   ifc.a_valid,   0);
    chk("rst_din_ready", ifc.din_ready, 0);
    chk("rst_count",     ifc.count,     0);
    cmp_en = 1'b1;
    @(negedge clk);
    ifc.din_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #2;
    chk("rel_din_ready", ifc.din_ready, 1);
    repeat (2) @(negedge clk);

    // Single word 0xDF, MSB first.
    ifc.din = 8'hDF; ifc.din_valid = 1'b1;
    @(negedge clk);
    ifc.din_valid = 1'b0;
    v8 = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      v8 = {v8[6:0], ifc.a};
      chk("single_valid", ifc.a_valid, 1);
    end
    chk("single_bits", v8, 8'hDF);
    @(posedge clk); #2;
    chk("single_after", ifc.a_valid, 0);

    // Back-to-back 0xA5, 0x3C.
    @(negedge clk);
    ifc.din = 8'hA5; ifc.din_valid = 1'b1;
    @(negedge clk);
    ifc.din = 8'h3C;
    v16 = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #2;
      v16 = {v16[14:0], ifc.a};
      chk("b2b_valid", ifc.a_valid, 1);
      chk("b2b_busy",  ifc.busy,    1);
      if (i == 0) begin
        @(negedge clk);
        ifc.din_valid = 1'b0;
      end
    end
    chk("b2b_bits", v16, 16'b1010010100111100);
    @(posedge clk); #2;
    chk("b2b_after", ifc.a_valid, 0);

    // Full FIFO: six words offered continuously.
    repeat (2) @(negedge clk);
    cap.delete();
    cap_en = 1'b1;
    k = 0; rel = 0; last_edge = -1;
    ifc.din = words[0]; ifc.din_valid = 1'b1;
    while (k < 6 && rel < 40) begin
      #1 rdy = ifc.din_ready;
      @(posedge clk);
      rel++;
      if (rdy) begin
        if (k == 5) last_edge = rel;
        k++;
      end
      #2;
      if (rel == 5) begin
        chk("full_count",     ifc.count,     4);
        chk("full_din_ready", ifc.din_ready, 0);
      end
      if (rel == 10) chk("full_reready", ifc.din_ready, 1);
      @(negedge clk);
      if (k < 6) ifc.din = words[k];
      else       ifc.din_valid = 1'b0;
    end
    chk("full_last_push_edge", last_edge, 11);
    repeat (45) @(posedge clk);
    #3;
    cap_en = 1'b0;
    chk("full_nbits", cap.size(), 48);
    v48 = '0;
    foreach (cap[i]) v48 = {v48[46:0], cap[i]};
    chk("full_bits", v48, 48'h112233445566);

    // Reset while shifting with two words queued.
    @(negedge clk);
    ifc.din = 8'hFF; ifc.din_valid = 1'b1;
    @(negedge clk);
    ifc.din = 8'h81;
    @(negedge clk);
    ifc.din = 8'h42;
    @(negedge clk);
    ifc.din_valid = 1'b0;
    @(negedge clk);
    chk("mid_pre_count", ifc.count,   2);
    chk("mid_pre_valid", ifc.a_valid, 1);
    rst = 1'b0;
    #1;
    chk("mid_a",       ifc.a,       0);
    chk("mid_a_valid", ifc.a_valid, 0);
    chk("mid_count",   ifc.count,   0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      chk("mid_quiet", ifc.a_valid, 0);
    end

    // LSB-first instance, word 0x01.
    @(negedge clk);
    ifl.din = 8'h01; ifl.din_valid = 1'b1;
    @(negedge clk);
    ifl.din_valid = 1'b0;
    v8 = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      v8[i] = ifl.a;
      chk("lsb_valid", ifl.a_valid, 1);
    end
    chk("lsb_bits", v8, 8'h01);
    @(posedge clk); #2;
    chk("lsb_after", ifl.a_valid, 0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Upstream feeder for the serial sequence detector.
- Accepts parallel words over a valid/ready interface and buffers them in a small FIFO.
- Shifts each word out one bit per clock on `a`, with a qualifying `a_valid`.
- Consecutive words are emitted gaplessly, so the detector sees a continuous bit stream when data is available.

Parameters:
- WIDTH, 8, bits per word; must be ≥ 2.
- DEPTH, 4, FIFO entries; must be a power of 2, ≥ 2.
- MSB_FIRST, 1, 1 = shift MSB first; 0 = shift LSB first.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  FIFO can accept; a push occurs on an edge where din_valid && din_ready.
- a  output  1  serial bit to the detector (registered).
- a_valid  output  1  `a` carries a real data bit this cycle (registered).
- busy  output  1  serializer is in SHIFT.
- count  output  $clog2(DEPTH)+1  FIFO occupancy; excludes the word in the shift register.

Behaviour:
- Reset (rst = 0, asynchronous):
  - a = 0, a_valid = 0, busy = 0, count = 0; FIFO pointers and bit counter cleared; state = IDLE.
  - din_ready is forced 0 while rst is low.
  - Reset mid-operation discards the in-flight word and all FIFO contents; no residual bits appear after release.
- din_ready = rst && (count != DEPTH). Combinational, with no dependence on din_valid.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Push and pop on the same edge leave count unchanged.
  - When full, no push is possible because din_ready = 0.
  - No bypass: a word pushed into an empty FIFO cannot be popped on the same edge.
- State machine, IDLE / SHIFT:
  - IDLE, FIFO empty: hold; a = 0, a_valid = 0.
  - IDLE, FIFO non-empty: on the edge, pop head to the shift register. a <= first bit (MSB if MSB_FIRST, else LSB); a_valid <= 1; bitcnt <= WIDTH-1; go to SHIFT.
  - SHIFT, bitcnt != 0: on the edge, a <= next bit; shift; bitcnt decrements.
  - SHIFT, bitcnt == 0 (last bit currently on `a`), FIFO non-empty: pop the next word exactly as from IDLE. a_valid stays 1, so there is no gap.
  - SHIFT, bitcnt == 0, FIFO empty: a <= 0, a_valid <= 0; go to IDLE.
- Latency: a word pushed at edge N with the serializer idle is visible on `a` after edge N+1. Its bits occupy edges N+1 .. N+WIDTH.
- Each word produces exactly WIDTH valid bits, in order. There is no loss or duplication under any din_valid pattern.
- a is 0 whenever a_valid is 0.

Test Plan:
- Reset: hold rst = 0 for 5 cycles with din_valid = 1 -> a = 0, a_valid = 0, din_ready = 0, count = 0. Release -> din_ready = 1 on the next cycle.
- Single word 0xDF, MSB_FIRST = 1, pushed at edge N -> a = 1,1,0,1,1,1,1,1 after edges N+1..N+8; a_valid high exactly those 8 cycles; low after N+9.
- Back-to-back 0xA5 then 0x3C on consecutive edges -> 16 contiguous valid bits 1010010100111100, a_valid never drops, busy high throughout.
- Full FIFO: din_valid held high with 6 distinct words from edge 1 (DEPTH = 4) -> count reaches 4 after edge 5 and din_ready = 0. Word 0 shifts out after edges 2–9; pop of word 1 at edge 10 re-raises din_ready; word 6 accepted at edge 11. All 48 bits emerge in order.
- Reset mid-word: assert rst after the 3rd bit of 0xFF with 2 words queued -> a_valid and a drop to 0 immediately, count = 0. After release, a_valid stays 0 until a new push.
- MSB_FIRST = 0, word 0x01 -> a = 1,0,0,0,0,0,0,0 with a_valid high for 8 cycles.
